charlie_scan_ctrl: RTL and testbench

- Sequencer and frame-buffer manager for the charlieplex LED driver.
- Walks `charlie_index` through the 56 non-diagonal positions of the 8x8 map. Index encoding: col = idx[2:0], row = idx[5:3].
- Holds each position for a programmable dwell time, then inserts blanking to suppress ghosting.
- Double-buffers the 64-bit frame so new images swap in only at scan wrap (no tearing). Its outputs feed the charlie driver's `charlie_index` and `memory_frame_buffer` inputs directly.

---
 rtl/charlie_pkg.sv | 21 ++
 rtl/charlie_next_idx.sv | 25 ++
 rtl/charlie_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_charlie_scan_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/charlie_pkg.sv
// rtl/charlie_pkg.sv - shared constants, state encoding and helpers for the charlieplex scan controller
package charlie_pkg;

    localparam int CHARLIE_ROWS  = 8;
    localparam int CHARLIE_IDX_W = 6;

    localparam logic [CHARLIE_IDX_W-1:0] FIRST_IDX = 6'd1;
    localparam logic [CHARLIE_IDX_W-1:0] LAST_IDX  = 6'd62;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } charlie_state_e;

    // A diagonal position drives the same pin as anode and cathode, so it has no LED.
    function automatic logic is_diag(input logic [CHARLIE_IDX_W-1:0] idx);
        return idx[5:3] == idx[2:0];
    endfunction

endpackage

// File: rtl/charlie_next_idx.sv
// rtl/charlie_next_idx.sv - combinational scan successor with diagonal skip and wrap flag
module charlie_next_idx
    import charlie_pkg::*;
(
    input  logic [CHARLIE_IDX_W-1:0] idx_i,
    output logic [CHARLIE_IDX_W-1:0] next_o,
    output logic                     wrap_o
);

    logic [CHARLIE_IDX_W-1:0] inc;

    // Diagonals are 9 apart, so a single extra step always clears one.
    always_comb begin
        inc    = idx_i + 6'd1;
        wrap_o = (idx_i == LAST_IDX);
        if (wrap_o) begin
            next_o = FIRST_IDX;
        end else if (is_diag(inc)) begin
            next_o = inc + 6'd1;
        end else begin
            next_o = inc;
        end
    end

endmodule

// File: rtl/charlie_scan_ctrl.sv
// rtl/charlie_scan_ctrl.sv - scan sequencer and double-buffered frame store; CHARLIE_SKIP_DARK_EN gives unlit positions a single clock
module charlie_scan_ctrl
    import charlie_pkg::*;
#(
    parameter int DWELL_CYCLES = 16,
    parameter int BLANK_CYCLES = 2,
    parameter int TIMER_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [63:0]              frame_data,
    input  logic                     frame_valid,
    output logic                     frame_ready,
    output logic [CHARLIE_IDX_W-1:0] charlie_index,
    output logic [63:0]              memory_frame_buffer,
    output logic                     frame_start,
    output logic [7:0]               frame_count
);

`ifdef CHARLIE_SKIP_DARK_EN
    localparam bit SKIP_DARK = 1'b1;
`else
    localparam bit SKIP_DARK = 1'b0;
`endif

    localparam logic [TIMER_W-1:0] DWELL_LOAD = TIMER_W'(DWELL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] BLANK_LOAD = TIMER_W'(BLANK_CYCLES - 1);

    charlie_state_e           state_q, state_d;
    logic [CHARLIE_IDX_W-1:0] idx_q, idx_d;
    logic [TIMER_W-1:0]       timer_q, timer_d;
    logic [63:0]              active_q, active_d;
    logic [63:0]              shadow_q, shadow_d;
    logic                     pending_q, pending_d;
    logic                     dark_q, dark_d;
    logic                     ready_q, ready_d;
    logic                     frame_start_q, frame_start_d;
    logic [7:0]               frame_count_q, frame_count_d;
    logic [63:0]              mfb_q, mfb_d;

    logic [CHARLIE_IDX_W-1:0] nxt_idx;
    logic                     nxt_wrap;
    logic                     advance;

    charlie_next_idx u_next_idx (
        .idx_i  (idx_q),
        .next_o (nxt_idx),
        .wrap_o (nxt_wrap)
    );

    // Next-state: handshake, dwell/blank sequencing, scan wrap with buffer swap, registered outputs.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        pending_d     = pending_q;
        dark_d        = dark_q;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;
        advance       = 1'b0;

        // Accept only into an empty shadow; swap needs pending, so the two never coincide.
        if (frame_valid && ready_q) begin
            shadow_d  = frame_data;
            pending_d = 1'b1;
        end

        if (!enable) begin
            state_d = IDLE;
            idx_d   = FIRST_IDX;
            timer_d = '0;
            dark_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d       = SHOW;
                    timer_d       = DWELL_LOAD;
                    frame_start_d = 1'b1;
                    dark_d        = 1'b0;
                    if (pending_q) begin
                        active_d  = shadow_q;
                        pending_d = 1'b0;
                    end
                end
                SHOW: begin
                    if (dark_q || timer_q == '0) begin
                        if (!dark_q && BLANK_CYCLES > 0) begin
                            state_d = BLANK;
                            timer_d = BLANK_LOAD;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                BLANK: begin
                    if (timer_q == '0) begin
                        advance = 1'b1;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (advance) begin
            state_d = SHOW;
            idx_d   = nxt_idx;
            timer_d = DWELL_LOAD;
            if (nxt_wrap) begin
                frame_count_d = frame_count_q + 8'd1;
                frame_start_d = 1'b1;
                if (pending_q) begin
                    active_d  = shadow_q;
                    pending_d = 1'b0;
                end
            end
            // Dark check uses the post-swap frame so the first position of a new image is judged correctly.
            dark_d = SKIP_DARK && !active_d[nxt_idx];
        end

        ready_d = !pending_d;
        mfb_d   = (state_d == SHOW && !dark_d) ? active_d : 64'd0;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= FIRST_IDX;
            timer_q       <= '0;
            active_q      <= '0;
            shadow_q      <= '0;
            pending_q     <= 1'b0;
            dark_q        <= 1'b0;
            ready_q       <= 1'b1;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
            mfb_q         <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            dark_q        <= dark_d;
            ready_q       <= ready_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            mfb_q         <= mfb_d;
        end
    end

    assign frame_ready         = ready_q;
    assign charlie_index       = idx_q;
    assign memory_frame_buffer = mfb_q;
    assign frame_start         = frame_start_q;
    assign frame_count         = frame_count_q;

endmodule

// File: tb/tb_charlie_scan_ctrl.sv
// tb/tb_charlie_scan_ctrl.sv - scoreboard bench for charlie_scan_ctrl, default and fast-scan instances
module tb_charlie_scan_ctrl;

`ifdef CHARLIE_SKIP_DARK_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    localparam logic [63:0] F1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] F2 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] FA = 64'h0F1E_2D3C_4B5A_6978;
    localparam logic [63:0] FB = 64'hA5A5_5A5A_F0F0_0F0F;
    localparam logic [63:0] FD = 64'h0000_0000_0000_0002;

    logic        clk = 1'b0;
    logic        rst_n, enable, frame_valid, frame_ready, frame_start;
    logic [63:0] frame_data, mfb;
    logic [5:0]  charlie_index;
    logic [7:0]  frame_count;

    logic        en_f, valid_f, ready_f, fs_f;
    logic [63:0] mfb_f;
    logic [5:0]  idx_f;
    logic [7:0]  cnt_f;

    typedef struct {
        logic [5:0]  idx;
        logic [63:0] frm;
        logic        fs;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] send_q[$];
    int          acc_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    charlie_scan_ctrl dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable              (enable),
        .frame_data          (frame_data),
        .frame_valid         (frame_valid),
        .frame_ready         (frame_ready),
        .charlie_index       (charlie_index),
        .memory_frame_buffer (mfb),
        .frame_start         (frame_start),
        .frame_count         (frame_count)
    );

    charlie_scan_ctrl #(.DWELL_CYCLES(1), .BLANK_CYCLES(0)) dut_f (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable              (en_f),
        .frame_data          (frame_data),
        .frame_valid         (valid_f),
        .frame_ready         (ready_f),
        .charlie_index       (idx_f),
        .memory_frame_buffer (mfb_f),
        .frame_start         (fs_f),
        .frame_count         (cnt_f)
    );

    function automatic logic [5:0] next_pos(input logic [5:0] p);
        logic [5:0] n;
        if (p == 6'd62) return 6'd1;
        n = p + 6'd1;
        if (n[5:3] == n[2:0]) n = n + 6'd1;
        return n;
    endfunction

    // Expected per-clock (index, frame, frame_start) for one whole scan of frame f.
    task automatic push_scan(input logic [63:0] f, input int dwell, input int blank, input bit from_idle);
        logic [5:0] p;
        bit         full;
        exp_t       e;
        p = 6'd1;
        for (int k = 0; k < 56; k++) begin
            full = !SKIP || f[p] || (k == 0 && from_idle);
            if (full) begin
                for (int d = 0; d < dwell; d++) begin
                    e.idx = p; e.frm = f; e.fs = (k == 0 && d == 0);
                    exp_q.push_back(e);
                end
                for (int b = 0; b < blank; b++) begin
                    e.idx = p; e.frm = 64'd0; e.fs = 1'b0;
                    exp_q.push_back(e);
                end
            end else begin
                e.idx = p; e.frm = 64'd0; e.fs = (k == 0);
                exp_q.push_back(e);
            end
            p = next_pos(p);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        enable = 1'b0;
        frame_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (charlie_index !== 6'd1) begin errors++; $display("FAIL reset_idx got %0d want 1", charlie_index); end
        checks++; if (mfb !== 64'd0) begin errors++; $display("FAIL reset_frame got %h want 0", mfb); end
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", frame_ready); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", frame_start); end
        checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", frame_count); end
        rst_n = 1'b1;
        tick();
        checks++; if (charlie_index !== 6'd1 || mfb !== 64'd0) begin errors++; $display("FAIL idle_out got idx %0d frm %h want 1 0", charlie_index, mfb); end
    endtask

    task automatic test_scan();
        exp_t e;
        int   c;
        frame_data = F1; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL idle_accept_ready got %b want 0", frame_ready); end
        checks++; if (mfb !== 64'd0) begin errors++; $display("FAIL idle_dark got %h want 0", mfb); end
        enable = 1'b1;
        push_scan(F1, 16, 2, 1'b1);
        c = 0;
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (charlie_index !== e.idx || mfb !== e.frm || frame_start !== e.fs) begin
                errors++;
                $display("FAIL scan c=%0d idx %0d/%0d frm %h/%h fs %b/%b (got/want)", c, charlie_index, e.idx, mfb, e.frm, frame_start, e.fs);
            end
            if (c == 0) begin
                checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL entry_swap_ready got %b want 1", frame_ready); end
            end
            c++;
        end
        tick();
        checks++;
        if (charlie_index !== 6'd1 || frame_start !== 1'b1 || frame_count !== 8'd1) begin
            errors++;
            $display("FAIL scan_wrap got idx %0d fs %b cnt %0d want 1 1 1", charlie_index, frame_start, frame_count);
        end
    endtask

    task automatic test_swap();
        exp_t e;
        int   c, len1;
        go_idle();
        enable = 1'b1;
        push_scan(F1, 16, 2, 1'b1);
        len1 = exp_q.size();
        push_scan(F2, 16, 2, 1'b0);
        c = 0;
        frame_data = F2;
        while (c < len1 + 18) begin
            frame_valid = (c == 100);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (charlie_index !== e.idx || mfb !== e.frm || frame_start !== e.fs) begin
                errors++;
                $display("FAIL swap c=%0d idx %0d/%0d frm %h/%h fs %b/%b (got/want)", c, charlie_index, e.idx, mfb, e.frm, frame_start, e.fs);
            end
            if (c == 100 || c == len1 - 1) begin
                checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL swap_pending_ready c=%0d got %b want 0", c, frame_ready); end
            end
            if (c == len1) begin
                checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL swap_done_ready got %b want 1", frame_ready); end
            end
            c++;
        end
        frame_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   c, len1, cnt0;
        bit   acc;
        go_idle();
        cnt0 = frame_count;
        send_q.delete(); acc_q.delete();
        send_q.push_back(FA); send_q.push_back(FB);
        enable = 1'b1;
        push_scan(F2, 16, 2, 1'b1);
        len1 = exp_q.size();
        push_scan(FA, 16, 2, 1'b0);
        push_scan(FB, 16, 2, 1'b0);
        c = 0;
        while (exp_q.size() > 0) begin
            if (send_q.size() > 0 && c >= 50) begin
                frame_valid = 1'b1; frame_data = send_q[0];
            end else begin
                frame_valid = 1'b0;
            end
            acc = frame_valid && frame_ready;
            tick();
            if (acc) begin
                void'(send_q.pop_front());
                acc_q.push_back(c);
            end
            e = exp_q.pop_front();
            checks++;
            if (charlie_index !== e.idx || mfb !== e.frm || frame_start !== e.fs) begin
                errors++;
                $display("FAIL b2b c=%0d idx %0d/%0d frm %h/%h fs %b/%b (got/want)", c, charlie_index, e.idx, mfb, e.frm, frame_start, e.fs);
            end
            c++;
        end
        frame_valid = 1'b0;
        checks++;
        if (acc_q.size() != 2) begin
            errors++; $display("FAIL b2b_accepts got %0d want 2", acc_q.size());
        end else begin
            checks++; if (acc_q[0] != 50) begin errors++; $display("FAIL b2b_accept_a got %0d want 50", acc_q[0]); end
            checks++; if (acc_q[1] != len1 + 1) begin errors++; $display("FAIL b2b_accept_b got %0d want %0d", acc_q[1], len1 + 1); end
        end
        tick();
        checks++;
        if (charlie_index !== 6'd1 || frame_start !== 1'b1 || mfb !== FB || frame_count !== 8'(cnt0 + 3)) begin
            errors++;
            $display("FAIL b2b_wrap got idx %0d fs %b frm %h cnt %0d want 1 1 %h %0d", charlie_index, frame_start, mfb, frame_count, FB, cnt0 + 3);
        end
    endtask

    task automatic test_enable_drop();
        exp_t e;
        go_idle();
        enable = 1'b1;
        push_scan(FB, 16, 2, 1'b1);
        e.idx = 6'd0;
        while (exp_q.size() > 0 && e.idx != 6'd20) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (charlie_index !== e.idx || mfb !== e.frm || frame_start !== e.fs) begin
                errors++;
                $display("FAIL en_scan idx %0d/%0d frm %h/%h fs %b/%b (got/want)", charlie_index, e.idx, mfb, e.frm, frame_start, e.fs);
            end
        end
        exp_q.delete();
        enable = 1'b0;
        tick();
        checks++; if (charlie_index !== 6'd1 || mfb !== 64'd0 || frame_start !== 1'b0) begin errors++; $display("FAIL en_drop got idx %0d frm %h fs %b want 1 0 0", charlie_index, mfb, frame_start); end
        tick();
        checks++; if (charlie_index !== 6'd1 || mfb !== 64'd0) begin errors++; $display("FAIL en_idle got idx %0d frm %h want 1 0", charlie_index, mfb); end
        enable = 1'b1;
        tick();
        checks++; if (charlie_index !== 6'd1 || mfb !== FB || frame_start !== 1'b1) begin errors++; $display("FAIL en_restart got idx %0d frm %h fs %b want 1 %h 1", charlie_index, mfb, frame_start, FB); end
        tick();
        checks++; if (charlie_index !== 6'd1 || mfb !== FB || frame_start !== 1'b0) begin errors++; $display("FAIL en_dwell got idx %0d frm %h fs %b want 1 %h 0", charlie_index, mfb, frame_start, FB); end
    endtask

    task automatic test_fast();
        exp_t e;
        int   c;
        en_f = 1'b1;
        push_scan(64'd0, 1, 0, 1'b1);
        push_scan(64'd0, 1, 0, 1'b0);
        push_scan(64'd0, 1, 0, 1'b0);
        c = 0;
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (idx_f !== e.idx || mfb_f !== e.frm || fs_f !== e.fs) begin
                errors++;
                $display("FAIL fast c=%0d idx %0d/%0d frm %h/%h fs %b/%b (got/want)", c, idx_f, e.idx, mfb_f, e.frm, fs_f, e.fs);
            end
            c++;
        end
        tick();
        checks++; if (cnt_f !== 8'd3 || fs_f !== 1'b1 || idx_f !== 6'd1) begin errors++; $display("FAIL fast_count got cnt %0d fs %b idx %0d want 3 1 1", cnt_f, fs_f, idx_f); end
        en_f = 1'b0;
    endtask

`ifdef CHARLIE_SKIP_DARK_EN
    task automatic test_skip_dark();
        exp_t e;
        int   c, fs2;
        go_idle();
        frame_data = FD; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        enable = 1'b1;
        push_scan(FD, 16, 2, 1'b1);
        push_scan(FD, 16, 2, 1'b0);
        c = 0; fs2 = -1;
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            if (frame_start === 1'b1 && c > 0 && fs2 < 0) fs2 = c;
            checks++;
            if (charlie_index !== e.idx || mfb !== e.frm || frame_start !== e.fs) begin
                errors++;
                $display("FAIL skip c=%0d idx %0d/%0d frm %h/%h fs %b/%b (got/want)", c, charlie_index, e.idx, mfb, e.frm, frame_start, e.fs);
            end
            c++;
        end
        checks++; if (fs2 != 73) begin errors++; $display("FAIL skip_period got %0d want 73", fs2); end
    endtask
`endif

    task automatic test_async_reset();
        go_idle();
        enable = 1'b1;
        repeat (30) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (charlie_index !== 6'd1 || mfb !== 64'd0 || frame_count !== 8'd0 || frame_ready !== 1'b1 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got idx %0d frm %h cnt %0d rdy %b fs %b want 1 0 0 1 0", charlie_index, mfb, frame_count, frame_ready, frame_start);
        end
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; frame_valid = 1'b0; frame_data = 64'd0;
        en_f = 1'b0; valid_f = 1'b0;
        test_reset();
        test_scan();
        test_swap();
        test_back_to_back();
        test_enable_drop();
        test_fast();
`ifdef CHARLIE_SKIP_DARK_EN
        test_skip_dark();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
